io_input_reader: RTL

- Memory-mapped input peripheral: the CPU-read counterpart of the segment-display write path.
- Samples board switches and one confirm button, debounces the button, and latches a switch snapshot on each confirmed press.
- Exposes live switches, and snapshot plus status, to the CPU load path through chip-select read ports.
- Reading status clears the pending press, giving a read-to-acknowledge handshake for polling software.

---
 rtl/io_input_reader_if.sv | 10 +
 rtl/io_input_reader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/io_input_reader_if.sv
// CPU load-path bus for the input peripheral: read strobe, chip selects and read data.
interface io_input_reader_if;
    logic        io_read;
    logic        sw_cs;
    logic        key_cs;
    logic [31:0] io_rdata;

    modport master (output io_read, sw_cs, key_cs, input io_rdata);
    modport slave  (input io_read, sw_cs, key_cs, output io_rdata);
endinterface

// File: rtl/io_input_reader.sv
// Switch/confirm-button input peripheral: synchronizes inputs, debounces the button,
// latches a switch snapshot per confirmed press and serves it through chip-select reads.
module io_input_reader #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                clk,
    input  logic                seg_rst,
    io_input_reader_if.slave    bus,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                confirm_btn,
    output logic                key_pending
);
    localparam int CW     = $clog2(DEBOUNCE_CYCLES);
    localparam int SNAP_W = (SW_WIDTH > 16) ? 16 : SW_WIDTH;
    localparam int LIVE_W = (SW_WIDTH > 32) ? 32 : SW_WIDTH;

    typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_t;

    logic [SW_WIDTH-1:0] sw_m, sw_s;
    logic                btn_m, btn_s;
    state_t              state, state_nx;
    logic [CW-1:0]       cnt, cnt_nx;
    logic                press_evt;
    logic [SNAP_W-1:0]   snapshot;
    logic                pending, overflow;
    logic                ack;

    always_ff @(posedge clk or negedge seg_rst) begin
        if (!seg_rst) begin
            sw_m  <= '0;
            sw_s  <= '0;
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sw_m  <= switches;
            sw_s  <= sw_m;
            btn_m <= confirm_btn;
            btn_s <= btn_m;
        end
    end

    always_ff @(posedge clk or negedge seg_rst) begin
        if (!seg_rst) begin
            state <= STABLE_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        press_evt = 1'b0;
        unique case (state)
            STABLE_LOW: if (btn_s) begin
                state_nx = WAIT_HIGH;
                cnt_nx   = '0;
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    state_nx = STABLE_LOW;
                    cnt_nx   = '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_nx  = STABLE_HIGH;
                    press_evt = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            STABLE_HIGH: if (!btn_s) begin
                state_nx = WAIT_LOW;
                cnt_nx   = '0;
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    state_nx = STABLE_HIGH;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    state_nx = STABLE_LOW;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = STABLE_LOW;
        endcase
    end

    assign ack = bus.io_read & bus.key_cs;

    // A press coinciding with a status read wins: the read consumes the old event,
    // so overflow only records presses that nobody acknowledged.
    always_ff @(posedge clk or negedge seg_rst) begin
        if (!seg_rst) begin
            snapshot <= '0;
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else if (press_evt) begin
            snapshot <= sw_s[SNAP_W-1:0];
            pending  <= 1'b1;
            overflow <= ack ? 1'b0 : (overflow | pending);
        end else if (ack) begin
            pending  <= 1'b0;
            overflow <= 1'b0;
        end
    end

    always_comb begin
        bus.io_rdata = '0;
        if (bus.io_read && bus.key_cs) begin
            bus.io_rdata[16 +: SNAP_W] = snapshot;
            bus.io_rdata[1]            = overflow;
            bus.io_rdata[0]            = pending;
        end else if (bus.io_read && bus.sw_cs) begin
            bus.io_rdata[LIVE_W-1:0] = sw_s[LIVE_W-1:0];
        end
    end

    assign key_pending = pending;
endmodule
